// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: instruction fetch front end. It issues one request at a time to
// instruction memory, stores returned words with their addresses in a small
// FIFO, and presents the oldest entry to a valid/ready consumer. A redirect
// flushes the FIFO and restarts fetch at a new word-aligned PC. If a request
// is still in flight when the redirect arrives, its response is discarded.
//
// Optional feature macro: FETCH_DECODE_EN adds decoded instruction field
// outputs (MIPS-style fields) taken from the head entry.
//
// Parameters:
//   ADDR_W        PC / instruction address width
//   DEPTH         instruction buffer entries (power of 2, >= 2)
//   RESET_VECTOR  fetch PC after reset
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   imem_req/addr    fetch request and address (held until imem_ack)
//   imem_ack/rdata   memory response valid and instruction word
//   redirect/target  taken jump/branch pulse and new PC
//   out_valid/ready  consumer handshake
//   out_instr/pc     head instruction word and its address
//   out_opcode..out_jaddr  decoded head fields (FETCH_DECODE_EN only)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_DECODE_EN
  ,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [15:0]       out_imm,
  output logic [25:0]       out_jaddr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_DEPTH  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1'b1);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  // IDLE: no request; REQ: request outstanding; DROP: outstanding request is stale
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] pc_r;        // next address to fetch
  logic [ADDR_W-1:0] pc_s;
  logic [ADDR_W-1:0] addr_r;      // address currently presented to memory
  logic [ADDR_W-1:0] addr_s;
  logic              req_r;

  logic [31:0]       instr_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              valid_s;
  logic              pop_s;
  logic              push_s;
  logic              flush_s;
  logic [CNT_W-1:0]  count_after_pop_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign valid_s           = (count_r != CNT_ZERO);
  assign pop_s             = valid_s & out_ready;
  // A pop in this cycle already frees a slot for the credit decision
  assign count_after_pop_s = count_r - {{(CNT_W-1){1'b0}}, pop_s};
  assign target_s          = redirect_target & ALIGN_MASK;
  assign pc_inc_s          = pc_r + PC_STEP;

  assign imem_req  = req_r;
  assign imem_addr = addr_r;
  assign out_valid = valid_s;
  assign out_instr = instr_mem_r[rd_ptr_r];
  assign out_pc    = pc_mem_r[rd_ptr_r];

`ifdef FETCH_DECODE_EN
  assign out_opcode = out_instr[31:26];
  assign out_rs     = out_instr[25:21];
  assign out_rt     = out_instr[20:16];
  assign out_rd     = out_instr[15:11];
  assign out_shamt  = out_instr[10:6];
  assign out_funct  = out_instr[5:0];
  assign out_imm    = out_instr[15:0];
  assign out_jaddr  = out_instr[25:0];
`endif

  // Next-state, fetch PC, request address and buffer control decisions
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    addr_s  = addr_r;
    push_s  = 1'b0;
    flush_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (redirect) begin
          flush_s = 1'b1;
          pc_s    = target_s;
          addr_s  = target_s;
          state_s = S_REQ;
        end else if (count_after_pop_s < CNT_DEPTH) begin
          addr_s  = pc_r;
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (imem_ack && redirect) begin
          // Response belongs to the old path: drop it, restart immediately
          flush_s = 1'b1;
          pc_s    = target_s;
          addr_s  = target_s;
          state_s = S_REQ;
        end else if (imem_ack) begin
          push_s = 1'b1;
          pc_s   = pc_inc_s;
          if ((count_after_pop_s + CNT_ONE) < CNT_DEPTH) begin
            addr_s  = pc_inc_s;
            state_s = S_REQ;
          end else begin
            state_s = S_IDLE;
          end
        end else if (redirect) begin
          // Request must stay on the bus until its ack; that ack is stale
          flush_s = 1'b1;
          pc_s    = target_s;
          state_s = S_DROP;
        end else begin
          state_s = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          flush_s = 1'b1;
          pc_s    = target_s;
        end else begin
          flush_s = 1'b0;
        end
        if (imem_ack) begin
          addr_s  = redirect ? target_s : pc_r;
          state_s = S_REQ;
        end else begin
          state_s = S_DROP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state, fetch PC and memory request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      pc_r    <= RESET_VECTOR;
      addr_r  <= RESET_VECTOR;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      addr_r  <= addr_s;
      req_r   <= (state_s != S_IDLE);
    end
  end

  // Instruction buffer storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'd0;
        pc_mem_r[i]    <= {ADDR_W{1'b0}};
      end
    end else if (flush_s) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= imem_rdata;
        pc_mem_r[wr_ptr_r]    <= addr_r;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_after_pop_s + (push_s ? CNT_ONE : CNT_ZERO);
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC/instruction address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries (power of 2, at least 2).
REQ-003 SHALL have parameter RESET_VECTOR, default 0, meaning PC value after reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-007 SHALL have port imem_addr  output  ADDR_W  fetch address.
REQ-008 SHALL have port imem_ack  input  1  memory response valid; variable latency, at least 1 cycle.
REQ-009 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-010 SHALL have port redirect  input  1  jump/branch taken; 1-cycle pulse.
REQ-011 SHALL have port redirect_target  input  ADDR_W  new PC, sampled when redirect=1.
REQ-012 SHALL have port out_valid  output  1  buffered instruction available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid and out_ready.
REQ-014 SHALL have port out_instr  output  32  head instruction word.
REQ-015 SHALL have port out_pc  output  ADDR_W  address of out_instr.

Function
REQ-016 SHALL run FSM states IDLE (no request), REQ (imem_req=1, awaiting ack), DROP (discard one stale ack).
REQ-017 SHALL hold imem_req and imem_addr stable from assertion until the cycle imem_ack=1.
REQ-018 SHALL keep at most one request outstanding.
REQ-019 SHALL issue a request only when entries plus outstanding requests < DEPTH (credit).
REQ-020 SHALL, on an ack cycle with no redirect, write {imem_rdata, imem_addr} into the buffer and advance the fetch PC by 4.
REQ-021 SHALL, on an ack cycle when credit remains after the write, stay in REQ with imem_addr+4 next cycle (back-to-back fetch); otherwise go to IDLE.
REQ-022 SHALL assert out_valid in the cycle after the buffer write at the earliest; out_instr/out_pc SHALL reflect the oldest entry (FIFO order).
REQ-023 SHALL allow simultaneous write and pop when full; pop frees credit seen in the same cycle.
REQ-024 SHALL wrap the fetch PC modulo 2^ADDR_W (2^ADDR_W-4 + 4 = 0).
REQ-025 SHALL, on redirect, flush all buffer entries (out_valid=0 next cycle), load the fetch PC with redirect_target with bits [1:0] forced to 0.
REQ-026 SHALL, on redirect while in REQ with no ack that cycle, enter DROP, discard the next ack's data, then issue a request to the new PC in the cycle after that ack.
REQ-027 SHALL, on redirect in the same cycle as an ack, discard that ack's data and enter REQ at the target next cycle (no DROP).
REQ-028 SHALL, on redirect in DROP, update the PC to the latest target and remain in DROP.
REQ-029 SHALL, on redirect together with a pop, complete the pop handshake for the consumer, then flush the buffer.
REQ-030 SHALL, on redirect in IDLE, enter REQ at the target next cycle.

Reset
REQ-031 SHALL on rst=1 set FSM=IDLE, fetch PC=RESET_VECTOR, buffer empty, imem_req=0, imem_addr=RESET_VECTOR, out_valid=0, out_instr=0, out_pc=0.
REQ-032 SHALL assert imem_req to RESET_VECTOR in the first cycle after rst deasserts.
REQ-033 SHALL, on rst during an outstanding request, drop it and ignore any ack arriving while rst=1.

Configuration
REQ-034 SHALL, with FETCH_DECODE_EN defined, add outputs out_opcode[5:0]=instr[31:26], out_rs[4:0]=[25:21], out_rt[4:0]=[20:16], out_rd[4:0]=[15:11], out_shamt[4:0]=[10:6], out_funct[5:0]=[5:0], out_imm[15:0]=[15:0], out_jaddr[25:0]=[25:0], taken from the head entry, 0 in reset.
REQ-035 SHALL, without FETCH_DECODE_EN, omit these ports; all other behaviour is identical.

Verification
REQ-036 SHALL cover: reset release with 1-cycle ack, out_ready=1 -> imem_addr 0,4,8,...; out_pc 0,4,8 in order, out_instr matches memory.
REQ-037 SHALL cover: out_ready=0, DEPTH=4 -> exactly 4 acks accepted, imem_req stays 0, out_pc=0 held; one pop -> one new request to 0x10.
REQ-038 SHALL cover: redirect to 0x103 while request at 0x8 pending with 3-cycle ack -> 0x8 data never output, next imem_addr=0x100, next out_pc=0x100.
REQ-039 SHALL cover: redirect in same cycle as ack -> acked word discarded, imem_addr=target next cycle, no DROP cycle.
REQ-040 SHALL cover: redirect to 0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000.
REQ-041 SHALL cover: FETCH_DECODE_EN, instruction 0x012A4020 -> opcode 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20.
